// File: rtl/acl_txpyld_buf.sv
//==============================================================================
// Module      : acl_txpyld_buf
// Description : Double-banked ACL-U TX payload buffer. The host fills the
//               staging bank while the encoder reads the active bank, driven
//               by ARQ send-new / resend / zero-length-continue decisions.
//               Optional retransmit counter: define ACLBUF_RETXCNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acl_txpyld_buf #(
  parameter  int MAXLEN = 339,
  localparam int AW     = $clog2(MAXLEN + 1)
) (
  input  logic          clk_6M,
  input  logic          rst,
  input  logic          host_wr_valid,
  input  logic [7:0]    host_wr_data,
  input  logic          host_wr_last,
  output logic          host_wr_ready,
  input  logic          sendnewpy_p,
  input  logic          sendoldpy_p,
  input  logic          send0cpy_p,
  input  logic          py_rd,
  output logic [7:0]    py_data,
  output logic [AW-1:0] py_len,
  output logic          py_busy,
  output logic          py_done_p,
  output logic          py_none,
`ifdef ACLBUF_RETXCNT_EN
  output logic [7:0]    retx_cnt,
`endif
  output logic          req_err_p
);

  localparam logic [AW-1:0] c_LASTPTR = AW'(MAXLEN - 1);

  typedef enum logic [0:0] {W_FILL = 1'b0, W_FULL = 1'b1} wst_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_SEND = 1'b1} rst_t;

  wst_t          r_wstate;
  rst_t          r_rstate;
  logic          r_act_bank;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_len [2];
  logic [AW-1:0] r_py_len;
  logic          r_busy;
  logic          r_done_p;
  logic          r_none;
  logic          r_err_p;
  logic [7:0]    r_mem [2][MAXLEN];
`ifdef ACLBUF_RETXCNT_EN
  logic [7:0]    r_retx_cnt;
`endif

  logic          w_wr_ready;
  logic          w_wr_fire;
  logic          w_any_req;
  logic [AW-1:0] w_act_len;

  assign w_wr_ready = (r_wstate == W_FILL);
  assign w_wr_fire  = host_wr_valid & w_wr_ready;
  assign w_any_req  = send0cpy_p | sendoldpy_p | sendnewpy_p;
  assign w_act_len  = r_len[r_act_bank];

  // Payload storage carries no reset; validity is tracked by r_len only.
  always_ff @(posedge clk_6M) begin
    if (w_wr_fire) begin
      r_mem[~r_act_bank][r_wptr] <= host_wr_data;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      r_wstate   <= W_FILL;
      r_rstate   <= R_IDLE;
      r_act_bank <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_py_len   <= '0;
      r_busy     <= 1'b0;
      r_done_p   <= 1'b0;
      r_none     <= 1'b0;
      r_err_p    <= 1'b0;
`ifdef ACLBUF_RETXCNT_EN
      r_retx_cnt <= 8'h00;
`endif
    end else begin
      r_done_p <= 1'b0;
      r_err_p  <= 1'b0;

      if (w_wr_fire) begin
        r_wptr <= r_wptr + AW'(1);
        if (host_wr_last || (r_wptr == c_LASTPTR)) begin
          r_len[~r_act_bank] <= r_wptr + AW'(1);
          r_wstate           <= W_FULL;
        end
      end

      if (r_rstate == R_SEND) begin
        if (w_any_req) begin
          r_err_p <= 1'b1;
        end
        if (py_rd) begin
          if (r_rptr == r_py_len - AW'(1)) begin
            r_done_p <= 1'b1;
            r_busy   <= 1'b0;
            r_rstate <= R_IDLE;
          end else begin
            r_rptr <= r_rptr + AW'(1);
          end
        end
      end else if (send0cpy_p) begin
        r_len[r_act_bank] <= '0;
        r_py_len          <= '0;
        r_done_p          <= 1'b1;
        r_none            <= 1'b0;
`ifdef ACLBUF_RETXCNT_EN
        r_retx_cnt        <= 8'h00;
`endif
      end else if (sendoldpy_p) begin
        r_rptr   <= '0;
        r_py_len <= w_act_len;
        if (w_act_len != '0) begin
          r_none   <= 1'b0;
          r_busy   <= 1'b1;
          r_rstate <= R_SEND;
`ifdef ACLBUF_RETXCNT_EN
          if (r_retx_cnt != 8'hff) begin
            r_retx_cnt <= r_retx_cnt + 8'h01;
          end
`endif
        end else begin
          r_none <= 1'b1;
        end
      end else if (sendnewpy_p) begin
        r_rptr <= '0;
        if (r_wstate == W_FULL) begin
          // Swap: the drained active bank becomes the new empty staging bank.
          r_act_bank        <= ~r_act_bank;
          r_py_len          <= r_len[~r_act_bank];
          r_len[r_act_bank] <= '0;
          r_wstate          <= W_FILL;
          r_wptr            <= '0;
          r_none            <= 1'b0;
          r_busy            <= 1'b1;
          r_rstate          <= R_SEND;
`ifdef ACLBUF_RETXCNT_EN
          r_retx_cnt        <= 8'h00;
`endif
        end else begin
          r_py_len <= '0;
          r_none   <= 1'b1;
        end
      end
    end
  end

  assign host_wr_ready = w_wr_ready;
  assign py_data       = (r_rstate == R_SEND) ? r_mem[r_act_bank][r_rptr] : 8'h00;
  assign py_len        = r_py_len;
  assign py_busy       = r_busy;
  assign py_done_p     = r_done_p;
  assign py_none       = r_none;
  assign req_err_p     = r_err_p;
`ifdef ACLBUF_RETXCNT_EN
  assign retx_cnt      = r_retx_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acl_txpyld_buf.sv
//==============================================================================
// Module      : tb_acl_txpyld_buf
// Description : Directed self-checking bench for acl_txpyld_buf.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_acl_txpyld_buf;

  localparam int MAXLEN = 339;
  localparam int AW     = $clog2(MAXLEN + 1);

  logic          clk_6M = 1'b0;
  logic          rst;
  logic          host_wr_valid;
  logic [7:0]    host_wr_data;
  logic          host_wr_last;
  logic          host_wr_ready;
  logic          sendnewpy_p;
  logic          sendoldpy_p;
  logic          send0cpy_p;
  logic          py_rd;
  logic [7:0]    py_data;
  logic [AW-1:0] py_len;
  logic          py_busy;
  logic          py_done_p;
  logic          py_none;
  logic          req_err_p;
`ifdef ACLBUF_RETXCNT_EN
  logic [7:0]    retx_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  acl_txpyld_buf #(.MAXLEN(MAXLEN)) u_dut (
    .clk_6M        (clk_6M),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_last  (host_wr_last),
    .host_wr_ready (host_wr_ready),
    .sendnewpy_p   (sendnewpy_p),
    .sendoldpy_p   (sendoldpy_p),
    .send0cpy_p    (send0cpy_p),
    .py_rd         (py_rd),
    .py_data       (py_data),
    .py_len        (py_len),
    .py_busy       (py_busy),
    .py_done_p     (py_done_p),
    .py_none       (py_none),
`ifdef ACLBUF_RETXCNT_EN
    .retx_cnt      (retx_cnt),
`endif
    .req_err_p     (req_err_p)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int kind, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (kind)
      0:       exp_byte = 8'h10 + b;
      1:       exp_byte = b ^ 8'h5A;
      default: exp_byte = 8'hA0 + b;
    endcase
  endfunction

  task automatic host_write(input int n, input int kind, input bit with_last);
    for (int i = 0; i < n; i++) begin
      host_wr_valid = 1'b1;
      host_wr_data  = exp_byte(kind, i);
      host_wr_last  = with_last && (i == n - 1);
      tick();
    end
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
  endtask

  task automatic pulse(input bit p0, input bit pold, input bit pnew);
    send0cpy_p  = p0;
    sendoldpy_p = pold;
    sendnewpy_p = pnew;
    tick();
    send0cpy_p  = 1'b0;
    sendoldpy_p = 1'b0;
    sendnewpy_p = 1'b0;
  endtask

  // Reads n bytes; if err_at>=0 a resend pulse is injected alongside that read.
  task automatic read_pay(input string tag, input int n, input int kind, input int err_at);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (py_data !== exp_byte(kind, i)) begin
        bad++;
        if (bad == 1) check({tag, "_data"}, 32'(py_data), 32'(exp_byte(kind, i)));
      end
      py_rd       = 1'b1;
      sendoldpy_p = (i == err_at);
      tick();
      sendoldpy_p = 1'b0;
      if (i == err_at) begin
        check({tag, "_err_p"}, 32'(req_err_p), 32'd1);
        check({tag, "_len_kept"}, 32'(py_len), 32'(n));
      end
    end
    py_rd = 1'b0;
    check({tag, "_bytes_ok"}, 32'(bad), 32'd0);
    check({tag, "_done_p"}, 32'(py_done_p), 32'd1);
    check({tag, "_busy_off"}, 32'(py_busy), 32'd0);
    tick();
    check({tag, "_done_clr"}, 32'(py_done_p), 32'd0);
  endtask

  initial begin
    rst = 1'b1; host_wr_valid = 1'b0; host_wr_data = 8'h00; host_wr_last = 1'b0;
    sendnewpy_p = 1'b0; sendoldpy_p = 1'b0; send0cpy_p = 1'b0; py_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 32'(host_wr_ready), 32'd1);
    check("rst_busy",  32'(py_busy),       32'd0);
    check("rst_len",   32'(py_len),        32'd0);
    check("rst_none",  32'(py_none),       32'd0);
    check("rst_data",  32'(py_data),       32'd0);
    check("rst_done",  32'(py_done_p),     32'd0);
    check("rst_err",   32'(req_err_p),     32'd0);
`ifdef ACLBUF_RETXCNT_EN
    check("rst_retx",  32'(retx_cnt),      32'd0);
`endif

    // 27-byte payload, new send
    host_write(27, 0, 1'b1);
    check("w27_full_ready", 32'(host_wr_ready), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("new27_len",   32'(py_len),        32'd27);
    check("new27_busy",  32'(py_busy),       32'd1);
    check("new27_ready", 32'(host_wr_ready), 32'd1);
    read_pay("new27", 27, 0, -1);

    // Two retransmissions
    pulse(1'b0, 1'b1, 1'b0);
    check("old1_len", 32'(py_len), 32'd27);
    read_pay("old1", 27, 0, -1);
    pulse(1'b0, 1'b1, 1'b0);
    read_pay("old2", 27, 0, -1);
`ifdef ACLBUF_RETXCNT_EN
    check("retx_2", 32'(retx_cnt), 32'd2);
`endif

    // sendnew with empty staging
    pulse(1'b0, 1'b0, 1'b1);
    check("none_flag", 32'(py_none), 32'd1);
    check("none_len",  32'(py_len),  32'd0);
    check("none_busy", 32'(py_busy), 32'd0);
    tick();
    check("none_hold", 32'(py_none), 32'd1);

    // Zero-length continue flushes the 27-byte active payload
    pulse(1'b1, 1'b0, 1'b0);
    check("c0_len",    32'(py_len),    32'd0);
    check("c0_done_p", 32'(py_done_p), 32'd1);
    check("c0_busy",   32'(py_busy),   32'd0);
    check("c0_none",   32'(py_none),   32'd0);
`ifdef ACLBUF_RETXCNT_EN
    check("c0_retx",   32'(retx_cnt),  32'd0);
`endif
    pulse(1'b0, 1'b1, 1'b0);
    check("c0_old_none", 32'(py_none), 32'd1);
    check("c0_old_busy", 32'(py_busy), 32'd0);

    // MAXLEN bytes without last forces FULL
    host_write(MAXLEN - 1, 1, 1'b0);
    check("max_ready_before", 32'(host_wr_ready), 32'd1);
    host_wr_valid = 1'b1; host_wr_data = exp_byte(1, MAXLEN - 1);
    tick();
    host_wr_valid = 1'b0;
    check("max_ready_full", 32'(host_wr_ready), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("max_len",  32'(py_len),  32'd339);
    check("max_none", 32'(py_none), 32'd0);
    read_pay("max", MAXLEN, 1, 100);
`ifdef ACLBUF_RETXCNT_EN
    check("max_retx", 32'(retx_cnt), 32'd0);
`endif
    check("max_err_clr", 32'(req_err_p), 32'd0);

    // Reset in the middle of a read-out
    host_write(5, 2, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("mid_len", 32'(py_len), 32'd5);
    py_rd = 1'b1; tick(); tick(); py_rd = 1'b0;
    check("mid_data2", 32'(py_data), 32'hA2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy",  32'(py_busy),       32'd0);
    check("mid_rst_ready", 32'(host_wr_ready), 32'd1);
    check("mid_rst_len",   32'(py_len),        32'd0);
    check("mid_rst_data",  32'(py_data),       32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("mid_rst_old_none", 32'(py_none), 32'd1);
    check("mid_rst_old_busy", 32'(py_busy), 32'd0);

    // Priority: continue beats simultaneous sendnew, no swap happens
    host_write(3, 2, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    check("prio_len",    32'(py_len),        32'd0);
    check("prio_done",   32'(py_done_p),     32'd1);
    check("prio_err",    32'(req_err_p),     32'd0);
    check("prio_ready",  32'(host_wr_ready), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("prio_new_len", 32'(py_len), 32'd3);
    read_pay("prio", 3, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
